// File: rtl/bp_fpga_host_pkg.sv
// Shared types for the FPGA host inbound path: packet layout, deserialiser states, error bit positions.
// The packet struct is a macro because its field widths follow the instantiating module's parameters.
`ifndef BP_FPGA_HOST_PKG_SV
`define BP_FPGA_HOST_PKG_SV

`define DECLARE_BP_FPGA_HOST_NBF_S(op_w, addr_w, data_w) \
  typedef struct packed {                                \
    logic [data_w-1:0] data;                             \
    logic [addr_w-1:0] addr;                             \
    logic [op_w-1:0]   opcode;                           \
  } bp_fpga_host_nbf_s

package bp_fpga_host_pkg;

  typedef enum logic [1:0] {
    e_opcode = 2'd0,
    e_addr   = 2'd1,
    e_data   = 2'd2
  } bp_fpga_host_deser_state_e;

  localparam int err_overrun_idx_gp = 0;
  localparam int err_frame_idx_gp   = 1;
  localparam int err_timeout_idx_gp = 2;
  localparam int err_flags_width_gp = 3;

endpackage

`endif

// File: rtl/bp_fpga_host_byte_shifter.sv
// Byte-indexed write register; data_o is the write-through view (stored bytes with this cycle's byte merged),
// so a field completed by the current byte can be consumed in the same cycle.
module bp_fpga_host_byte_shifter #(
  parameter int width_p     = 64,
  parameter int idx_width_p = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   we_i,
  input  logic [idx_width_p-1:0] idx_i,
  input  logic [7:0]             byte_i,
  output logic [width_p-1:0]     data_o
);

  localparam int bytes_lp = width_p / 8;

  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    for (int b = 0; b < bytes_lp; b++) begin
      if (we_i && (idx_i == idx_width_p'(b))) begin
        data_d[8*b +: 8] = byte_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_d;

endmodule

// File: rtl/bp_one_fifo.sv
// One-element FIFO with valid/yumi output; a dequeue and an enqueue may share a cycle.
// Latency 1 cycle; ready_o stays high while full if the consumer takes the entry this cycle.
module bp_one_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic               full_q;
  logic [width_p-1:0] data_q;

  assign ready_o = ~full_q | yumi_i;
  assign v_o     = full_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (v_i && ready_o) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (yumi_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bp_fpga_host_nbf_deser.sv
// Assembles UART bytes (opcode, addr LSB-first, data LSB-first) into NBF packets behind a one-entry valid/yumi buffer.
// Packet visible 1 cycle after its last byte; bytes cannot be stalled, so a completion into a full buffer is dropped as overrun.
module bp_fpga_host_nbf_deser
  import bp_fpga_host_pkg::*;
#(
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p   = 40,
  parameter int nbf_data_width_p   = 64,
  parameter int timeout_cycles_p   = 1048576
) (
  input  logic                                                         clk_i,
  input  logic                                                         reset_i,
  input  logic [7:0]                                                   byte_i,
  input  logic                                                         byte_v_i,
  input  logic                                                         frame_err_i,
  output logic [nbf_opcode_width_p+nbf_addr_width_p+nbf_data_width_p-1:0] nbf_o,
  output logic                                                         nbf_v_o,
  input  logic                                                         nbf_yumi_i,
  output logic                                                         error_o,
  output logic [err_flags_width_gp-1:0]                                err_flags_o,
  input  logic                                                         err_clr_i
);

  localparam int addr_bytes_lp = nbf_addr_width_p / 8;
  localparam int data_bytes_lp = nbf_data_width_p / 8;
  localparam int max_bytes_lp  = (addr_bytes_lp > data_bytes_lp) ? addr_bytes_lp : data_bytes_lp;
  localparam int cnt_width_lp  = $clog2(max_bytes_lp);
  localparam int tmo_width_lp  = $clog2(timeout_cycles_p);
  localparam int nbf_width_lp  = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;

  `DECLARE_BP_FPGA_HOST_NBF_S(nbf_opcode_width_p, nbf_addr_width_p, nbf_data_width_p);

  bp_fpga_host_deser_state_e state_q, state_d;
  logic [cnt_width_lp-1:0]       cnt_q, cnt_d;
  logic [tmo_width_lp-1:0]       tmo_q, tmo_d;
  logic [nbf_opcode_width_p-1:0] opcode_q, opcode_d;
  logic [err_flags_width_gp-1:0] err_q, err_d, err_ev;

  logic byte_accept, tmo_hit, addr_last, data_last;
  logic opcode_we, addr_we, data_we, pkt_done;
  logic fifo_ready;

  logic [nbf_addr_width_p-1:0] addr_asm;
  logic [nbf_data_width_p-1:0] data_asm;
  bp_fpga_host_nbf_s           pkt_asm;
  logic [nbf_width_lp-1:0]     pkt_buf;

  // A byte arriving alongside a framing error is part of the corrupted stream and is dropped.
  assign byte_accept = byte_v_i & ~frame_err_i;
  assign addr_last   = (cnt_q == cnt_width_lp'(addr_bytes_lp - 1));
  assign data_last   = (cnt_q == cnt_width_lp'(data_bytes_lp - 1));
  assign tmo_hit     = (state_q != e_opcode) & ~byte_v_i
                     & (tmo_q == tmo_width_lp'(timeout_cycles_p - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_opcode;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_err_i || tmo_hit) begin
      state_d = e_opcode;
    end else if (byte_accept) begin
      unique case (state_q)
        e_opcode: state_d = e_addr;
        e_addr:   state_d = addr_last ? e_data : e_addr;
        e_data:   state_d = data_last ? e_opcode : e_data;
        default:  state_d = e_opcode;
      endcase
    end
  end

  always_comb begin
    opcode_we = 1'b0;
    addr_we   = 1'b0;
    data_we   = 1'b0;
    pkt_done  = 1'b0;
    unique case (state_q)
      e_opcode: opcode_we = byte_accept;
      e_addr:   addr_we   = byte_accept;
      e_data: begin
        data_we  = byte_accept;
        pkt_done = byte_accept & data_last;
      end
      default: ;
    endcase
  end

  // Any state change (or abort) restarts the field byte index.
  always_comb begin
    cnt_d = cnt_q;
    if (frame_err_i || tmo_hit || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (byte_accept && (state_q != e_opcode)) begin
      cnt_d = cnt_q + cnt_width_lp'(1);
    end
  end

  always_comb begin
    tmo_d = tmo_q + tmo_width_lp'(1);
    if ((state_d == e_opcode) || byte_v_i) begin
      tmo_d = '0;
    end
  end

  assign opcode_d = opcode_we ? byte_i : opcode_q;

  always_comb begin
    err_ev                     = '0;
    err_ev[err_overrun_idx_gp] = pkt_done & ~fifo_ready;
    err_ev[err_frame_idx_gp]   = frame_err_i;
    err_ev[err_timeout_idx_gp] = tmo_hit;
    err_d = (err_clr_i ? '0 : err_q) | err_ev;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      tmo_q    <= '0;
      opcode_q <= '0;
      err_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      opcode_q <= opcode_d;
      err_q    <= err_d;
    end
  end

  bp_fpga_host_byte_shifter #(
    .width_p     (nbf_addr_width_p),
    .idx_width_p (cnt_width_lp)
  ) addr_shifter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (addr_we),
    .idx_i   (cnt_q),
    .byte_i  (byte_i),
    .data_o  (addr_asm)
  );

  bp_fpga_host_byte_shifter #(
    .width_p     (nbf_data_width_p),
    .idx_width_p (cnt_width_lp)
  ) data_shifter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (data_we),
    .idx_i   (cnt_q),
    .byte_i  (byte_i),
    .data_o  (data_asm)
  );

  always_comb begin
    pkt_asm        = '0;
    pkt_asm.opcode = opcode_q;
    pkt_asm.addr   = addr_asm;
    pkt_asm.data   = data_asm;
  end

  bp_one_fifo #(
    .width_p (nbf_width_lp)
  ) out_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (pkt_asm),
    .v_i     (pkt_done),
    .ready_o (fifo_ready),
    .data_o  (pkt_buf),
    .v_o     (nbf_v_o),
    .yumi_i  (nbf_yumi_i)
  );

  assign nbf_o       = pkt_buf;
  assign err_flags_o = err_q;
  assign error_o     = |err_q;

endmodule
